subbytes_sched: RTL and testbench

SUBBYTES_SCHED -- requirements
Module: subbytes_sched

---
 rtl/subbytes_sched.sv | 200 ++++++++++++++++++++
 tb/tb_subbytes_sched.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subbytes_sched.sv
// -----------------------------------------------------------------------------
// subbytes_sched
//
// Shares a single external 4-byte S-box lane between two requesters:
//   - the state requester (128-bit SubBytes, pushed through the lane as four
//     32-bit words, word 0 = bits [31:0] first)
//   - the key-expansion requester (32-bit SubWord, one pass through the lane)
//
// Only one request is in flight at a time. Requests are accepted only in IDLE.
// When both requesters are valid in the same IDLE cycle, a 1-bit round-robin
// (last_grant) favours the one not granted last. There is no preemption.
//
// Handshake rule, identical on all four channels: a transfer happens on a
// rising edge where valid and ready are both high. Request readies are only
// high in IDLE. A response holds valid and data stable until its ready is
// seen high; the block then returns to IDLE on that edge, so a new request
// can never be accepted in the same cycle as a response handshake.
//
// Optional build macro:
//   SBOX_PIPE_EN  - the external lane is registered; sb_out is captured one
//                   cycle after the matching sb_in. Adds one pass cycle to
//                   each operation (state 5 pass cycles, key word 2).
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   st_req_valid/ready/data  128-bit state request
//   st_rsp_valid/ready/data  128-bit substituted state
//   kw_req_valid/ready/data  32-bit key-word request
//   kw_rsp_valid/ready/data  32-bit substituted word
//   sb_in                    operand to the shared lane (0 when not passing)
//   sb_out                   lane result, byte-wise S-box of sb_in
//   busy                     high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module subbytes_sched (
   input  logic         clk,
   input  logic         rst,
   input  logic         st_req_valid,
   output logic         st_req_ready,
   input  logic [127:0] st_req_data,
   output logic         st_rsp_valid,
   input  logic         st_rsp_ready,
   output logic [127:0] st_rsp_data,
   input  logic         kw_req_valid,
   output logic         kw_req_ready,
   input  logic [31:0]  kw_req_data,
   output logic         kw_rsp_valid,
   input  logic         kw_rsp_ready,
   output logic [31:0]  kw_rsp_data,
   output logic [31:0]  sb_in,
   input  logic [31:0]  sb_out,
   output logic         busy
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ST_PASS = 3'd1;
   localparam logic [2:0] KW_PASS = 3'd2;
   localparam logic [2:0] ST_RSP  = 3'd3;
   localparam logic [2:0] KW_RSP  = 3'd4;

   localparam logic GRANT_ST = 1'b0;
   localparam logic GRANT_KW = 1'b1;

   logic [2:0]   state;
   logic [1:0]   word_cnt;
   logic         issue_done;   // all four state words have been sent to the lane
   logic         last_grant;
   logic [127:0] st_data;
   logic [31:0]  kw_data;
   logic [127:0] st_result;
   logic [31:0]  kw_result;

   logic         idle;
   logic         grant_st;
   logic         grant_kw;
   logic         st_issue;
   logic         kw_issue;
   logic         st_cap;
   logic [1:0]   st_cap_idx;
   logic         kw_cap;
   logic         st_last;

   assign idle     = (state == IDLE);
   assign grant_st = st_req_valid && (!kw_req_valid || (last_grant == GRANT_KW));
   assign grant_kw = kw_req_valid && (!st_req_valid || (last_grant == GRANT_ST));

   assign st_req_ready = idle && grant_st;
   assign kw_req_ready = idle && grant_kw;

   assign st_issue = (state == ST_PASS) && !issue_done;

`ifdef SBOX_PIPE_EN
   // The lane result lags its operand by one cycle, so the capture side is a
   // delayed copy of the issue side.
   logic       cap_vld_q;
   logic [1:0] cap_idx_q;
   logic       kw_cap_q;

   assign kw_issue   = (state == KW_PASS) && !kw_cap_q;
   assign st_cap     = cap_vld_q;
   assign st_cap_idx = cap_idx_q;
   assign kw_cap     = kw_cap_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_vld_q <= 1'b0;
         cap_idx_q <= 2'd0;
         kw_cap_q  <= 1'b0;
      end else begin
         cap_vld_q <= st_issue;
         cap_idx_q <= word_cnt;
         kw_cap_q  <= kw_issue;
      end
   end
`else
   // Combinational lane: the result is captured in the cycle it is issued.
   assign kw_issue   = (state == KW_PASS);
   assign st_cap     = st_issue;
   assign st_cap_idx = word_cnt;
   assign kw_cap     = kw_issue;
`endif

   assign st_last = st_cap && (st_cap_idx == 2'd3);

   always_comb begin
      sb_in = 32'h0;
      if (st_issue) begin
         sb_in = st_data[{word_cnt, 5'd0} +: 32];
      end else if (kw_issue) begin
         sb_in = kw_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         word_cnt   <= 2'd0;
         issue_done <= 1'b0;
         last_grant <= GRANT_ST;
         st_data    <= 128'h0;
         kw_data    <= 32'h0;
         st_result  <= 128'h0;
         kw_result  <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (st_req_ready) begin
                  st_data    <= st_req_data;
                  word_cnt   <= 2'd0;
                  issue_done <= 1'b0;
                  last_grant <= GRANT_ST;
                  state      <= ST_PASS;
               end else if (kw_req_ready) begin
                  kw_data    <= kw_req_data;
                  last_grant <= GRANT_KW;
                  state      <= KW_PASS;
               end
            end
            ST_PASS: begin
               if (st_issue) begin
                  // 2-bit counter wraps 3 -> 0 on the last issued word.
                  word_cnt <= word_cnt + 2'd1;
                  if (word_cnt == 2'd3) begin
                     issue_done <= 1'b1;
                  end
               end
               if (st_cap) begin
                  st_result[{st_cap_idx, 5'd0} +: 32] <= sb_out;
               end
               if (st_last) begin
                  state <= ST_RSP;
               end
            end
            KW_PASS: begin
               if (kw_cap) begin
                  kw_result <= sb_out;
                  state     <= KW_RSP;
               end
            end
            ST_RSP: begin
               if (st_rsp_ready) begin
                  state <= IDLE;
               end
            end
            KW_RSP: begin
               if (kw_rsp_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign st_rsp_valid = (state == ST_RSP);
   assign kw_rsp_valid = (state == KW_RSP);
   assign st_rsp_data  = st_result;
   assign kw_rsp_data  = kw_result;
   assign busy         = !idle;

endmodule

// File: tb/tb_subbytes_sched.sv
// -----------------------------------------------------------------------------
// tb_subbytes_sched
//
// Bench for subbytes_sched. Provides a behavioural S-box lane (combinational,
// or registered when SBOX_PIPE_EN is defined) and expects latencies to match
// the selected build. Expected responses are queued at request accept and
// popped at the response handshake.
// -----------------------------------------------------------------------------
module tb_subbytes_sched;

   logic         clk = 1'b0;
   logic         rst;
   logic         st_req_valid;
   logic         st_req_ready;
   logic [127:0] st_req_data;
   logic         st_rsp_valid;
   logic         st_rsp_ready;
   logic [127:0] st_rsp_data;
   logic         kw_req_valid;
   logic         kw_req_ready;
   logic [31:0]  kw_req_data;
   logic         kw_rsp_valid;
   logic         kw_rsp_ready;
   logic [31:0]  kw_rsp_data;
   logic [31:0]  sb_in;
   logic [31:0]  sb_out;
   logic         busy;

`ifdef SBOX_PIPE_EN
   localparam int ST_LAT = 6;
   localparam int KW_LAT = 3;
`else
   localparam int ST_LAT = 5;
   localparam int KW_LAT = 2;
`endif

   localparam logic [2047:0] SBOX_TAB = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   int tests = 0;
   int fails = 0;
   logic [127:0] exp_st_q[$];
   logic [31:0]  exp_kw_q[$];

   subbytes_sched dut (
      .clk          (clk),
      .rst          (rst),
      .st_req_valid (st_req_valid),
      .st_req_ready (st_req_ready),
      .st_req_data  (st_req_data),
      .st_rsp_valid (st_rsp_valid),
      .st_rsp_ready (st_rsp_ready),
      .st_rsp_data  (st_rsp_data),
      .kw_req_valid (kw_req_valid),
      .kw_req_ready (kw_req_ready),
      .kw_req_data  (kw_req_data),
      .kw_rsp_valid (kw_rsp_valid),
      .kw_rsp_ready (kw_rsp_ready),
      .kw_rsp_data  (kw_rsp_data),
      .sb_in        (sb_in),
      .sb_out       (sb_out),
      .busy         (busy)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- S-box lane model ----------------
   function automatic logic [31:0] sbox_word(input logic [31:0] w);
      logic [31:0] r;
      int idx;
      r = 32'h0;
      for (int b = 0; b < 4; b++) begin
         idx = int'(w[8*b +: 8]);
         r[8*b +: 8] = SBOX_TAB[2047 - 8*idx -: 8];
      end
      return r;
   endfunction

   function automatic logic [127:0] sbox_state(input logic [127:0] d);
      logic [127:0] r;
      for (int n = 0; n < 4; n++) begin
         r[32*n +: 32] = sbox_word(d[32*n +: 32]);
      end
      return r;
   endfunction

`ifdef SBOX_PIPE_EN
   always @(posedge clk or posedge rst) begin
      if (rst) sb_out <= 32'h0;
      else     sb_out <= sbox_word(sb_in);
   end
`else
   always_comb sb_out = sbox_word(sb_in);
`endif

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      exp_st_q.delete();
      exp_kw_q.delete();
   endtask

   task automatic st_start(input logic [127:0] d, input logic [127:0] exp);
      int n;
      @(negedge clk);
      st_req_valid = 1'b1;
      st_req_data  = d;
      #1;
      n = 0;
      while (st_req_ready !== 1'b1 && n < 20) begin
         @(negedge clk); #1; n++;
      end
      tests++;
      if (st_req_ready !== 1'b1) begin
         fails++;
         $display("FAIL st_accept: st_req_ready=%b, required 1 within 20 cycles", st_req_ready);
      end
      @(posedge clk);
      exp_st_q.push_back(exp);
      @(negedge clk);
      st_req_valid = 1'b0;
      #1;
   endtask

   task automatic kw_start(input logic [31:0] d, input logic [31:0] exp);
      int n;
      @(negedge clk);
      kw_req_valid = 1'b1;
      kw_req_data  = d;
      #1;
      n = 0;
      while (kw_req_ready !== 1'b1 && n < 20) begin
         @(negedge clk); #1; n++;
      end
      tests++;
      if (kw_req_ready !== 1'b1) begin
         fails++;
         $display("FAIL kw_accept: kw_req_ready=%b, required 1 within 20 cycles", kw_req_ready);
      end
      @(posedge clk);
      exp_kw_q.push_back(exp);
      @(negedge clk);
      kw_req_valid = 1'b0;
      #1;
   endtask

   // Called in cycle 1 after the accept edge; checks lane operands, latency,
   // hold stability, handshake data and return to IDLE.
   task automatic st_collect(input logic [127:0] d, input int hold);
      int lat;
      logic [31:0]  exp_sb;
      logic [127:0] exp;
      lat = 1;
      while (st_rsp_valid !== 1'b1 && lat < 20) begin
         exp_sb = 32'h0;
         if (lat <= 4) exp_sb = d[32*(lat-1) +: 32];
         tests++;
         if (sb_in !== exp_sb) begin
            fails++;
            $display("FAIL st_sb_in cycle %0d: got %h, required %h", lat, sb_in, exp_sb);
         end
         @(negedge clk); #1; lat++;
      end
      tests++;
      if (lat != ST_LAT) begin
         fails++;
         $display("FAIL st_latency: got %0d, required %0d", lat, ST_LAT);
      end
      exp = 128'h0;
      if (exp_st_q.size() == 0) begin
         tests++; fails++;
         $display("FAIL st_scoreboard: response with empty expected queue");
      end else begin
         exp = exp_st_q.pop_front();
      end
      for (int h = 0; h < hold; h++) begin
         tests++;
         if (st_rsp_valid !== 1'b1 || st_rsp_data !== exp || st_req_ready !== 1'b0 ||
             kw_req_ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL st_hold cycle %0d: valid=%b data=%h rdy=%b/%b busy=%b, required 1 %h 0/0 1",
                     h, st_rsp_valid, st_rsp_data, st_req_ready, kw_req_ready, busy, exp);
         end
         @(negedge clk); #1;
      end
      st_rsp_ready = 1'b1;
      #1;
      tests++;
      if (st_rsp_valid !== 1'b1 || st_rsp_data !== exp || st_req_ready !== 1'b0 || kw_req_ready !== 1'b0) begin
         fails++;
         $display("FAIL st_rsp_data: valid=%b data=%h rdy=%b/%b, required 1 %h 0/0",
                  st_rsp_valid, st_rsp_data, st_req_ready, kw_req_ready, exp);
      end
      @(posedge clk);
      @(negedge clk);
      st_rsp_ready = 1'b0;
      #1;
      tests++;
      if (st_rsp_valid !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL st_release: valid=%b busy=%b, required 0 0", st_rsp_valid, busy);
      end
   endtask

   task automatic kw_collect(input logic [31:0] d, input int hold);
      int lat;
      logic [31:0] exp;
      lat = 1;
      while (kw_rsp_valid !== 1'b1 && lat < 20) begin
         if (lat == 1) begin
            tests++;
            if (sb_in !== d) begin
               fails++;
               $display("FAIL kw_sb_in: got %h, required %h", sb_in, d);
            end
         end
         @(negedge clk); #1; lat++;
      end
      tests++;
      if (lat != KW_LAT) begin
         fails++;
         $display("FAIL kw_latency: got %0d, required %0d", lat, KW_LAT);
      end
      exp = 32'h0;
      if (exp_kw_q.size() == 0) begin
         tests++; fails++;
         $display("FAIL kw_scoreboard: response with empty expected queue");
      end else begin
         exp = exp_kw_q.pop_front();
      end
      for (int h = 0; h < hold; h++) begin
         tests++;
         if (kw_rsp_valid !== 1'b1 || kw_rsp_data !== exp || st_req_ready !== 1'b0 ||
             kw_req_ready !== 1'b0 || busy !== 1'b1 || sb_in !== 32'h0) begin
            fails++;
            $display("FAIL kw_hold cycle %0d: valid=%b data=%h rdy=%b/%b busy=%b sb_in=%h, required 1 %h 0/0 1 0",
                     h, kw_rsp_valid, kw_rsp_data, st_req_ready, kw_req_ready, busy, sb_in, exp);
         end
         @(negedge clk); #1;
      end
      kw_rsp_ready = 1'b1;
      #1;
      tests++;
      if (kw_rsp_valid !== 1'b1 || kw_rsp_data !== exp || st_req_ready !== 1'b0 || kw_req_ready !== 1'b0) begin
         fails++;
         $display("FAIL kw_rsp_data: valid=%b data=%h rdy=%b/%b, required 1 %h 0/0",
                  kw_rsp_valid, kw_rsp_data, st_req_ready, kw_req_ready, exp);
      end
      @(posedge clk);
      @(negedge clk);
      kw_rsp_ready = 1'b0;
      #1;
      tests++;
      if (kw_rsp_valid !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL kw_release: valid=%b busy=%b, required 0 0", kw_rsp_valid, busy);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      tests++;
      if (busy !== 1'b0 || st_rsp_valid !== 1'b0 || kw_rsp_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_flags: busy=%b st_v=%b kw_v=%b, required 0 0 0", busy, st_rsp_valid, kw_rsp_valid);
      end
      tests++;
      if (st_rsp_data !== 128'h0 || kw_rsp_data !== 32'h0) begin
         fails++;
         $display("FAIL reset_data: st=%h kw=%h, required 0 0", st_rsp_data, kw_rsp_data);
      end
      tests++;
      if (sb_in !== 32'h0) begin
         fails++;
         $display("FAIL reset_sb_in: got %h, required 0", sb_in);
      end
      tests++;
      if (st_req_ready !== 1'b0 || kw_req_ready !== 1'b0) begin
         fails++;
         $display("FAIL reset_ready: st=%b kw=%b, required 0 0", st_req_ready, kw_req_ready);
      end
   endtask

   // Runs right after reset: grants must go kw, st, kw.
   task automatic test_arbitration();
      logic [127:0] sd;
      logic [31:0]  kd;
      logic         want_kw;
      do_reset();
      for (int r = 0; r < 3; r++) begin
         want_kw = (r != 1);
         sd = {$urandom, $urandom, $urandom, $urandom};
         kd = $urandom;
         @(negedge clk);
         st_req_valid = 1'b1; st_req_data = sd;
         kw_req_valid = 1'b1; kw_req_data = kd;
         #1;
         tests++;
         if (kw_req_ready !== want_kw || st_req_ready !== !want_kw) begin
            fails++;
            $display("FAIL arb_grant round %0d: kw_rdy=%b st_rdy=%b, required %b %b",
                     r, kw_req_ready, st_req_ready, want_kw, !want_kw);
         end
         @(posedge clk);
         if (want_kw) exp_kw_q.push_back(sbox_word(kd));
         else         exp_st_q.push_back(sbox_state(sd));
         @(negedge clk);
         st_req_valid = 1'b0;
         kw_req_valid = 1'b0;
         #1;
         if (want_kw) kw_collect(kd, 0);
         else         st_collect(sd, 0);
      end
   endtask

   task automatic test_state_directed();
      st_start(128'h0, 128'h63636363636363636363636363636363);
      st_collect(128'h0, 0);
      st_start(128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816);
      st_collect(128'h00112233445566778899aabbccddeeff, 0);
   endtask

   task automatic test_kw_directed();
      kw_start(32'h01020304, 32'h7c777bf2);
      kw_collect(32'h01020304, 0);
   endtask

   task automatic test_back_pressure();
      logic [127:0] sd;
      logic [31:0]  kd;
      sd = {$urandom, $urandom, $urandom, $urandom};
      kd = $urandom;
      st_start(sd, sbox_state(sd));
      st_collect(sd, 3);
      kw_start(kd, sbox_word(kd));
      kw_collect(kd, 3);
   endtask

   task automatic test_reset_mid();
      logic [127:0] sd;
      sd = 128'hdeadbeef_01234567_89abcdef_f00dcafe;
      st_start(sd, sbox_state(sd));
      @(negedge clk); #1;
      @(negedge clk); #1;
      tests++;
      if (sb_in !== sd[95:64]) begin
         fails++;
         $display("FAIL rstmid_word2: sb_in=%h, required %h", sb_in, sd[95:64]);
      end
      rst = 1'b1;
      #1;
      tests++;
      if (busy !== 1'b0 || sb_in !== 32'h0 || st_rsp_valid !== 1'b0) begin
         fails++;
         $display("FAIL rstmid_async: busy=%b sb_in=%h st_v=%b, required 0 0 0", busy, sb_in, st_rsp_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      exp_st_q.delete();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk); #1;
         tests++;
         if (busy !== 1'b0 || st_rsp_valid !== 1'b0 || sb_in !== 32'h0) begin
            fails++;
            $display("FAIL rstmid_quiet cycle %0d: busy=%b st_v=%b sb_in=%h, required 0 0 0",
                     c, busy, st_rsp_valid, sb_in);
         end
      end
      st_start(sd, sbox_state(sd));
      st_collect(sd, 0);
   endtask

   task automatic test_random();
      logic [127:0] sd;
      logic [31:0]  kd;
      int hold;
      for (int i = 0; i < 10; i++) begin
         hold = $urandom_range(0, 2);
         if ($urandom_range(0, 1) == 1) begin
            sd = {$urandom, $urandom, $urandom, $urandom};
            st_start(sd, sbox_state(sd));
            st_collect(sd, hold);
         end else begin
            kd = $urandom;
            kw_start(kd, sbox_word(kd));
            kw_collect(kd, hold);
         end
      end
   endtask

   // ---------------- main sequence / report ----------------
   initial begin
      rst          = 1'b1;
      st_req_valid = 1'b0;
      st_req_data  = 128'h0;
      st_rsp_ready = 1'b0;
      kw_req_valid = 1'b0;
      kw_req_data  = 32'h0;
      kw_rsp_ready = 1'b0;

      test_reset();
      test_arbitration();
      test_state_directed();
      test_kw_directed();
      test_back_pressure();
      test_reset_mid();
      test_random();

      tests++;
      if (exp_st_q.size() != 0 || exp_kw_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d state and %0d key-word expectations left, required 0 0",
                  exp_st_q.size(), exp_kw_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
